// File: rtl/hold_judge_pkg.sv
// Shared types and helpers for the hold/press judge: per-channel state encoding
// and the counter-width function.
package hold_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // Counter must be able to represent HOLD_CYCLES itself (saturation value).
  function automatic int unsigned cnt_width(input int unsigned hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/hold_judge_channel.sv
// One press-classification channel: FSM, saturating hold counter and, when
// HOLD_PRESS_TOGGLE_EN is defined, a power toggle flipped by each long press.
module hold_judge_channel
  import hold_judge_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned MIN_PRESS   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic held,
  output logic long_press,
  output logic short_press,
  output logic power_state
);

  localparam int unsigned   CW       = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_PRESS);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            held_n, long_n, short_n;

  // State, counter and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      held        <= 1'b0;
      long_press  <= 1'b0;
      short_press <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      held        <= held_n;
      long_press  <= long_n;
      short_press <= short_n;
    end
  end

  // Next-state and next-output decode; pulses default low so they last one cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    held_n  = held;
    long_n  = 1'b0;
    short_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sig_in) begin
          state_n = ST_COUNT;
          cnt_n   = CW'(1);
        end else begin
          cnt_n   = '0;
        end
      end
      ST_COUNT: begin
        if (sig_in) begin
          if (cnt + CW'(1) == HOLD_MAX) begin
            state_n = ST_HELD;
            cnt_n   = HOLD_MAX;
            held_n  = 1'b1;
            long_n  = 1'b1;
          end else begin
            cnt_n   = cnt + CW'(1);
          end
        end else begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          short_n = (cnt >= MIN_CNT);
        end
      end
      ST_HELD: begin
        if (sig_in) begin
          cnt_n   = HOLD_MAX;
        end else begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          held_n  = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        held_n  = 1'b0;
      end
    endcase
  end

`ifdef HOLD_PRESS_TOGGLE_EN
  logic toggle;

  // Flips on the same edge that raises long_press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else if (long_n) begin
      toggle <= ~toggle;
    end
  end

  assign power_state = toggle;
`else
  assign power_state = held;
`endif

endmodule

// File: rtl/hold_press_judge.sv
// Multi-channel hold/press classifier; power_state behaviour selected by
// HOLD_PRESS_TOGGLE_EN (toggle register) or its absence (copy of held).
module hold_press_judge
  import hold_judge_pkg::*;
#(
  parameter int unsigned N_CH        = 1,
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned MIN_PRESS   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sig_in,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] short_press,
  output logic [N_CH-1:0] power_state
);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("hold_press_judge: HOLD_CYCLES must be >= 2");
  end

  if (MIN_PRESS < 1 || MIN_PRESS >= HOLD_CYCLES) begin : g_bad_min
    $error("hold_press_judge: MIN_PRESS must be in 1..HOLD_CYCLES-1");
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    hold_judge_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .MIN_PRESS   (MIN_PRESS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .sig_in      (sig_in[i]),
      .held        (held[i]),
      .long_press  (long_press[i]),
      .short_press (short_press[i]),
      .power_state (power_state[i])
    );
  end

endmodule

// File: tb/tb_hold_press_judge.sv
// Scoreboard bench for hold_press_judge (N_CH=2, HOLD_CYCLES=50, MIN_PRESS=3);
// the power_state expectation follows HOLD_PRESS_TOGGLE_EN when defined.
module tb_hold_press_judge;

  localparam int unsigned N_CH = 2;

  typedef struct {
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] lp;
    logic [N_CH-1:0] sp;
    logic [N_CH-1:0] ps;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] sig_in;
  logic [N_CH-1:0] held, long_press, short_press, power_state;

  exp_t            sb_q[$];
  logic [N_CH-1:0] ps_model;
  int              checks;
  int              errors;
  int              cycle_no;

  hold_press_judge #(
    .N_CH        (N_CH),
    .HOLD_CYCLES (50),
    .MIN_PRESS   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .held        (held),
    .long_press  (long_press),
    .short_press (short_press),
    .power_state (power_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cycle_no, act, exp_v);
    end
  endtask

  // Drive one sample at the falling edge; queue what must be visible after the next rising edge
  task automatic cyc(input logic r, input logic [N_CH-1:0] s,
                     input logic [N_CH-1:0] eh, input logic [N_CH-1:0] el,
                     input logic [N_CH-1:0] es);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    sig_in = s;
`ifdef HOLD_PRESS_TOGGLE_EN
    if (!r) ps_model = '0;
    else    ps_model = ps_model ^ el;
`else
    ps_model = eh;
`endif
    e.held = eh;
    e.lp   = el;
    e.sp   = es;
    e.ps   = ps_model;
    sb_q.push_back(e);
  endtask

  // Monitor: one queued expectation per rising edge, compared 2 time units later
  initial begin
    exp_t e;
    cycle_no = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cycle_no++;
        chk("held",        held,        e.held);
        chk("long_press",  long_press,  e.lp);
        chk("short_press", short_press, e.sp);
        chk("power_state", power_state, e.ps);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    ps_model = '0;
    rst_n    = 1'b0;
    sig_in   = '0;

    // Reset state
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 2; k++) cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 1: 49 high samples -> short press on release, never held
    for (int k = 1; k <= 49; k++) cyc(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 2: 200 high samples -> held from the 50th, single long pulse, no wrap
    for (int k = 1; k <= 200; k++)
      cyc(1'b1, 2'b01, (k >= 50) ? 2'b01 : 2'b00, (k == 50) ? 2'b01 : 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 3: 2-sample glitch rejected, then exactly MIN_PRESS samples accepted
    for (int k = 1; k <= 2; k++) cyc(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 3; k++) cyc(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 4: ch0 held 60 cycles; ch1 10-cycle press released so its short pulse aligns with ch0 long
    for (int k = 1; k <= 60; k++) begin
      logic [N_CH-1:0] s, eh, el, es;
      s    = 2'b01;
      s[1] = (k >= 40 && k <= 49);
      eh   = (k >= 50) ? 2'b01 : 2'b00;
      el   = (k == 50) ? 2'b01 : 2'b00;
      es   = (k == 50) ? 2'b10 : 2'b00;
      cyc(1'b1, s, eh, el, es);
    end
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 5: reset at count 30 aborts the press; a new press needs 50 fresh samples
    for (int k = 1; k <= 30; k++) cyc(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) cyc(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 52; k++)
      cyc(1'b1, 2'b01, (k >= 50) ? 2'b01 : 2'b00, (k == 50) ? 2'b01 : 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // 6: long, short, long on ch0 -> power_state per build
    for (int k = 1; k <= 55; k++)
      cyc(1'b1, 2'b01, (k >= 50) ? 2'b01 : 2'b00, (k == 50) ? 2'b01 : 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int k = 1; k <= 52; k++)
      cyc(1'b1, 2'b01, (k >= 50) ? 2'b01 : 2'b00, (k == 50) ? 2'b01 : 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // Drain scoreboard
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
